lsu_mem_stage: RTL and testbench

Memory-access stage of the RV32I pipeline, directly downstream of the ALU. Takes the ALU result as the effective address (or pass-through result), performs byte/half/word loads and stores over a request/grant/response data-memory port, and hands an aligned, extended result to writeback. It stalls the execute stage through a ready signal while a bus transaction is outstanding.

---
 rtl/lsu_mem_stage.sv | 193 +++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Memory-access stage of the RV32I pipeline.
// Turns the ALU result into a data-memory request (byte/half/word load or
// store). It hands an aligned, extended result to writeback one cycle after
// the instruction completes.
//
// Handshakes:
//   ex_valid/ex_ready : a transfer happens on a rising edge where both are
//                       high. ex_ready depends only on the FSM state, so it
//                       never depends on ex_valid.
//   dmem_req/dmem_gnt : the request and its addr/we/be/wdata are held stable
//                       until dmem_gnt is sampled high. dmem_req drops the
//                       following cycle.
//   dmem_rvalid       : honoured only while a load waits for its response,
//                       and never in the grant cycle itself.
//   wb_valid          : one-cycle pulse with no backpressure.
module lsu_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_rs2,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic [31:0] wb_data,
    output logic        wb_exc
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        regwrite_q;

    logic        accept;
    logic        is_mem;
    logic        fault;
    logic [1:0]  off;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] sel;
    logic [31:0] load_data;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_mem_rd || ex_mem_wr;
    assign off      = ex_aluout[1:0];

    // Classify the incoming instruction: conflicting op, misalignment or bad width code.
    always_comb begin
        fault = 1'b0;
        if (ex_mem_rd && ex_mem_wr)
            fault = 1'b1;
        if (is_mem && (ex_funct3[1:0] == 2'b01) && off[0])
            fault = 1'b1;
        if (is_mem && (ex_funct3 == 3'b010) && (off != 2'b00))
            fault = 1'b1;
        if (ex_mem_rd && ((ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111)))
            fault = 1'b1;
        if (ex_mem_wr && (ex_funct3 > 3'b010))
            fault = 1'b1;
    end

    // Byte enables and lane-replicated store data for the addressed bytes.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = ex_rs2;
        case (ex_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << off;
                wdata_calc = {4{ex_rs2[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << off;
                wdata_calc = {2{ex_rs2[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = ex_rs2;
            end
        endcase
    end

    // Shift the addressed lane down and sign/zero-extend to 32 bits.
    always_comb begin
        sel       = dmem_rdata >> {off_q, 3'b000};
        load_data = dmem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{sel[7]}}, sel[7:0]};
            3'b001:  load_data = {{16{sel[15]}}, sel[15:0]};
            3'b100:  load_data = {24'h0, sel[7:0]};
            3'b101:  load_data = {16'h0, sel[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // FSM with registered bus and writeback outputs; wb fields return to 0 after each pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            rd_q        <= 5'd0;
            regwrite_q  <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'h0;
            dmem_be     <= 4'h0;
            dmem_wdata  <= 32'h0;
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            wb_regwrite <= 1'b0;
            wb_data     <= 32'h0;
            wb_exc      <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            wb_regwrite <= 1'b0;
            wb_data     <= 32'h0;
            wb_exc      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (fault) begin
                            wb_valid <= 1'b1;
                            wb_exc   <= 1'b1;
                            wb_rd    <= ex_rd;
                        end else if (is_mem) begin
                            off_q      <= off;
                            funct3_q   <= ex_funct3;
                            rd_q       <= ex_rd;
                            regwrite_q <= ex_regwrite;
                            dmem_req   <= 1'b1;
                            dmem_we    <= ex_mem_wr;
                            dmem_addr  <= {ex_aluout[31:2], 2'b00};
                            dmem_be    <= be_calc;
                            dmem_wdata <= wdata_calc;
                            state      <= REQ;
                        end else begin
                            wb_valid    <= 1'b1;
                            wb_rd       <= ex_rd;
                            wb_regwrite <= ex_regwrite;
                            wb_data     <= ex_aluout;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= 32'h0;
                        dmem_be    <= 4'h0;
                        dmem_wdata <= 32'h0;
                        if (dmem_we) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            state    <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        wb_valid    <= 1'b1;
                        wb_rd       <= rd_q;
                        wb_regwrite <= regwrite_q;
                        wb_data     <= load_data;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus randomized
// operations compared against a behavioural model of the stage.
module tb_lsu_mem_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid, ex_ready, ex_mem_rd, ex_mem_wr, ex_regwrite;
  logic [31:0] ex_aluout, ex_rs2;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_regwrite, wb_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  lsu_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_aluout(ex_aluout), .ex_rs2(ex_rs2),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .wb_data(wb_data), .wb_exc(wb_exc)
  );

  // ---------------- scoreboard counters / checker ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] a);
    if (!rd && !wr) return 1'b0;
    if (rd && wr) return 1'b1;
    if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b1;
    if (wr && f3 > 2) return 1'b1;
    if ((a % size_bytes(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned mask;
    mask = (1 << size_bytes(f3)) - 1;
    return (mask << (a % 4)) & 32'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_bytes(f3))
      1: return (d % 256) * 32'h01010101;
      2: return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: v = rdata;
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge of the writeback cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd, input bit mrd, input bit mwr,
                        input logic [2:0] f3, input bit rw, input logic [31:0] rdata,
                        input int gdly, input int rdly);
    bit flt, mem;
    flt = model_fault(mrd, mwr, f3, a);
    mem = (mrd || mwr) && !flt;
    check({tag, ".ready"}, ex_ready, 1);
    ex_valid = 1; ex_aluout = a; ex_rs2 = d; ex_rd = rd;
    ex_mem_rd = mrd; ex_mem_wr = mwr; ex_funct3 = f3; ex_regwrite = rw;
    @(negedge clk);
    ex_valid = 0; ex_mem_rd = 0; ex_mem_wr = 0;
    if (mem) begin
      for (int i = 1; i <= gdly; i++) begin
        check({tag, ".req"}, dmem_req, 1);
        check({tag, ".addr"}, dmem_addr, a & 32'hFFFFFFFC);
        check({tag, ".we"}, dmem_we, mwr);
        if (mwr) begin
          check({tag, ".be"}, dmem_be, model_be(f3, a));
          check({tag, ".wdata"}, dmem_wdata, model_wdata(f3, d));
        end
        check({tag, ".busy"}, ex_ready, 0);
        check({tag, ".nowb"}, wb_valid, 0);
        if (i == gdly) begin
          dmem_gnt = 1;
          if (mrd && ($urandom_range(0, 1) == 1)) begin
            dmem_rvalid = 1; dmem_rdata = ~rdata;
          end
        end
        @(negedge clk);
      end
      dmem_gnt = 0; dmem_rvalid = 0;
      if (mrd) begin
        for (int j = 1; j <= rdly; j++) begin
          check({tag, ".reqdrop"}, dmem_req, 0);
          check({tag, ".nowb2"}, wb_valid, 0);
          if (j == rdly) begin dmem_rvalid = 1; dmem_rdata = rdata; end
          @(negedge clk);
        end
        dmem_rvalid = 0;
      end
    end else begin
      check({tag, ".noreq"}, dmem_req, 0);
    end
    check({tag, ".wbv"}, wb_valid, 1);
    check({tag, ".wbexc"}, wb_exc, flt);
    check({tag, ".wbrd"}, wb_rd, rd);
    check({tag, ".wbrw"}, wb_regwrite, (flt || mwr) ? 1'b0 : rw);
    if (!flt) begin
      if (mrd) check({tag, ".wbdata"}, wb_data, model_load(f3, a, rdata));
      else if (mwr) check({tag, ".wbdata"}, wb_data, 0);
      else check({tag, ".wbdata"}, wb_data, a);
    end
    check({tag, ".readyafter"}, ex_ready, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, d;
    int kind;
    logic [2:0] f3;
    ex_valid = 0; ex_aluout = 0; ex_rs2 = 0; ex_mem_rd = 0; ex_mem_wr = 0;
    ex_funct3 = 0; ex_rd = 0; ex_regwrite = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    #1;
    check("rst.req", dmem_req, 0);
    check("rst.wbv", wb_valid, 0);
    check("rst.addr", dmem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst.ready", ex_ready, 1);

    // back-to-back non-memory ops
    ex_valid = 1; ex_aluout = 32'h11; ex_rd = 5'd3; ex_regwrite = 1;
    @(negedge clk);
    check("b2b.ready1", ex_ready, 1);
    check("b2b.wbv1", wb_valid, 1);
    check("b2b.data1", wb_data, 32'h11);
    ex_aluout = 32'h22; ex_rd = 5'd4;
    @(negedge clk);
    ex_valid = 0;
    check("b2b.ready2", ex_ready, 1);
    check("b2b.wbv2", wb_valid, 1);
    check("b2b.data2", wb_data, 32'h22);
    check("b2b.rd2", wb_rd, 5'd4);
    @(negedge clk);
    check("b2b.idle", wb_valid, 0);

    // directed memory cases
    run_op("sb", 32'h1003, 32'hAABBCCDD, 5'd7, 0, 1, 3'b000, 1, 0, 3, 1);
    run_op("lb", 32'h1002, 0, 5'd8, 1, 0, 3'b000, 1, 32'h80FF7F00, 1, 1);
    run_op("lbu", 32'h1002, 0, 5'd9, 1, 0, 3'b100, 1, 32'h80FF7F00, 2, 2);
    run_op("lh", 32'h1002, 0, 5'd10, 1, 0, 3'b001, 1, 32'h80FF7F00, 1, 3);
    run_op("lwmis", 32'h1001, 0, 5'd11, 1, 0, 3'b010, 1, 0, 1, 1);
    run_op("shmis", 32'h2003, 32'h1234, 5'd12, 0, 1, 3'b001, 1, 0, 1, 1);
    run_op("lwmin", 32'h3000, 0, 5'd13, 1, 0, 3'b010, 1, 32'hCAFEF00D, 1, 1);

    // spurious rvalid while idle
    dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    dmem_rvalid = 0;
    check("spur.wbv", wb_valid, 0);
    @(negedge clk);
    check("spur.wbv2", wb_valid, 0);

    // reset while waiting for a load response
    ex_valid = 1; ex_aluout = 32'h4000; ex_mem_rd = 1; ex_funct3 = 3'b010; ex_rd = 5'd14;
    @(negedge clk);
    ex_valid = 0; ex_mem_rd = 0;
    check("rresp.req", dmem_req, 1);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    check("rresp.busy", ex_ready, 0);
    #2 rst_n = 0;
    #1;
    check("rresp.req0", dmem_req, 0);
    check("rresp.wbv0", wb_valid, 0);
    check("rresp.be0", dmem_be, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rresp.ready", ex_ready, 1);
    dmem_rvalid = 1; dmem_rdata = 32'h5555AAAA;
    @(negedge clk);
    dmem_rvalid = 0;
    check("rresp.late", wb_valid, 0);
    @(negedge clk);
    check("rresp.late2", wb_valid, 0);

    // randomized operations
    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & 32'hFFFFFFFC | (32'($urandom_range(0, 1)) << 1);
      d = $urandom;
      run_op("rnd", a, d, 5'($urandom_range(0, 31)),
             (kind >= 2 && kind <= 5) || kind == 9, (kind >= 6),
             f3, 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(1, 4), $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
